dac_spi_frame_rx: RTL and testbench
===================================

// Module: dac_spi_frame_rx
// PURPOSE
//  SPI responder for the DAC link driven by the AO correction path (dac_sclk/dac_mosi/dac_cs_n).
//  Oversamples the three SPI lines with clk and deserializes each cs_n-framed word into cmd/addr/data.
//  Keeps the last written X and Y codes and flags malformed frames.
//  Used as the DAC-side loopback monitor in simulation and as the on-chip self-check in hardware.
// PARAMETERS
//  FRAME_BITS   24  bits per frame, MSB first: {cmd[3:0], addr[3:0], data[DATA_BITS-1:0]}
//  DATA_BITS    16  DAC code width; FRAME_BITS must equal DATA_BITS+8
//  SYNC_STAGES  2   flip-flop synchronizer depth on sclk, mosi and cs_n (minimum 2)
//  CMD_WRITE    4'h3 cmd value that updates code_x/code_y (write-and-update)
// PORTS
//  clk          in   1          system clock; must be >= 4x the sclk frequency
//  reset        in   1          synchronous, active-high
//  spi_sclk     in   1          SPI clock, asynchronous to clk, mode 0 (CPOL=0, CPHA=0)
//  spi_mosi     in   1          SPI data in
//  spi_cs_n     in   1          SPI chip select, active-low
//  frame_valid  out  1          one-cycle pulse: a good frame was captured
//  frame_cmd    out  4          cmd field of the last good frame
//  frame_addr   out  4          addr field of the last good frame
//  frame_data   out  DATA_BITS  data field of the last good frame
//  code_x       out  DATA_BITS  last data written with CMD_WRITE to addr 0
//  code_y       out  DATA_BITS  last data written with CMD_WRITE to addr 1
//  frame_err    out  1          one-cycle pulse: frame closed with bit count != FRAME_BITS
//  frame_cnt    out  16         count of good frames; wraps 16'hFFFF -> 0
//  err_cnt      out  8          count of bad frames; saturates at 8'hFF
// BEHAVIOUR
//  - Reset: every output is 0, FSM goes to IDLE, shift register and bit counter are cleared.
//    Reset asserted mid-frame discards the partial frame; the FSM re-arms only on the next cs_n fall.
//  - sclk, mosi and cs_n each pass through SYNC_STAGES FFs, then one edge-detect register.
//    All further logic uses the synchronized copies only.
//  - FSM states:
//    IDLE:  wait for a synchronized cs_n falling edge -> SHIFT (bit counter = 0).
//    SHIFT: each synchronized sclk rising edge does shreg <= {shreg, mosi_sync} and bitcnt++.
//           bitcnt saturates at FRAME_BITS+1; reaching the saturation value sets an overflow flag.
//           A cs_n rising edge -> CHECK.
//    CHECK: one cycle.
//           If bitcnt == FRAME_BITS and no overflow: load frame_cmd/addr/data, pulse frame_valid,
//           frame_cnt++, and update code_x (addr 0) or code_y (addr 1) only if cmd == CMD_WRITE.
//           Otherwise: pulse frame_err, err_cnt++ (saturating); frame_* and code_* hold.
//           Then -> IDLE.
//  - Latency: frame_valid/frame_err assert SYNC_STAGES+2 clk cycles after the cs_n pin rises.
//    frame_* and code_* change in that same cycle and then hold until the next good frame.
//  - sclk edges while cs_n is high, or while in IDLE, are ignored.
//  - cs_n rising with 0 bits shifted is an error (glitch frame).
//  - sclk rising in the same synchronized cycle as cs_n rising: the bit is NOT shifted (cs_n wins).
//  - sclk rising in the same synchronized cycle as cs_n falling: the bit IS shifted (first bit).
//  - addr >= 2 or cmd != CMD_WRITE: frame_valid still pulses; code_x/code_y are untouched.
//  - A cs_n fall during CHECK is captured: the FSM enters SHIFT directly after CHECK.
// TESTING
//  1 Reset, then send 24'h30_1234 (cmd 3, addr 0) -> one frame_valid pulse; code_x=16'h1234,
//    code_y=0, frame_cnt=1.
//  2 Send 24'h31_ABCD -> code_y=16'hABCD, code_x keeps 16'h1234; pulse SYNC_STAGES+2 clks after cs_n rise.
//  3 Send 24'h20_5555 (cmd 2) -> frame_valid pulses with frame_cmd=2; code_x stays 16'h1234.
//  4 Send 23-bit and 25-bit frames -> two frame_err pulses, err_cnt=2, no frame_valid,
//    frame_* unchanged.
//  5 Toggle sclk 8 times with cs_n high, then send 24'h31_0001 -> code_y=16'h0001
//    (the idle edges are ignored).
//  6 Assert reset after bit 12 of a frame, release, send 24'h30_00FF -> code_x=16'h00FF,
//    frame_cnt=1, err_cnt=0.

Source files
------------

// File: rtl/dac_spi_frame_rx.sv
// SPI mode-0 responder for the DAC link. It oversamples sclk/mosi/cs_n with clk and
// deserializes each cs_n-framed word into cmd/addr/data. It also tracks the X/Y codes.
module dac_spi_frame_rx #(
    parameter int         FRAME_BITS  = 24,
    parameter int         DATA_BITS   = 16,
    parameter int         SYNC_STAGES = 2,
    parameter logic [3:0] CMD_WRITE   = 4'h3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 spi_sclk,
    input  logic                 spi_mosi,
    input  logic                 spi_cs_n,
    output logic                 frame_valid,
    output logic [3:0]           frame_cmd,
    output logic [3:0]           frame_addr,
    output logic [DATA_BITS-1:0] frame_data,
    output logic [DATA_BITS-1:0] code_x,
    output logic [DATA_BITS-1:0] code_y,
    output logic                 frame_err,
    output logic [15:0]          frame_cnt,
    output logic [7:0]           err_cnt
);

    localparam int CNT_W = $clog2(FRAME_BITS + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_r;
    logic [SYNC_STAGES-1:0] mosi_sync_r;
    logic [SYNC_STAGES-1:0] cs_sync_r;
    logic                   sclk_prev_r;
    logic                   cs_prev_r;

    logic                   sclk_rise_s;
    logic                   cs_rise_s;
    logic                   cs_fall_s;
    logic                   mosi_s;
    logic [FRAME_BITS-1:0]  shift_next_s;
    logic [FRAME_BITS-1:0]  start_shreg_s;
    logic [CNT_W-1:0]       start_cnt_s;
    logic [3:0]             cmd_s;
    logic [3:0]             addr_s;
    logic                   frame_ok_s;

    state_t                 state_r;
    logic [FRAME_BITS-1:0]  shreg_r;
    logic [CNT_W-1:0]       bitcnt_r;
    logic                   ovf_r;
    logic                   frame_valid_r;
    logic                   frame_err_r;
    logic [3:0]             frame_cmd_r;
    logic [3:0]             frame_addr_r;
    logic [DATA_BITS-1:0]   frame_data_r;
    logic [DATA_BITS-1:0]   code_x_r;
    logic [DATA_BITS-1:0]   code_y_r;
    logic [15:0]            frame_cnt_r;
    logic [7:0]             err_cnt_r;

    // Synchronizers and edge-detect registers. cs_n resets low ("busy") so that a frame
    // still in progress when reset releases never looks like a fresh cs_n fall.
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_sync_r <= {SYNC_STAGES{1'b0}};
            mosi_sync_r <= {SYNC_STAGES{1'b0}};
            cs_sync_r   <= {SYNC_STAGES{1'b0}};
            sclk_prev_r <= 1'b0;
            cs_prev_r   <= 1'b0;
        end else begin
            sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], spi_sclk};
            mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], spi_mosi};
            cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], spi_cs_n};
            sclk_prev_r <= sclk_sync_r[SYNC_STAGES-1];
            cs_prev_r   <= cs_sync_r[SYNC_STAGES-1];
        end
    end

    assign sclk_rise_s  = sclk_sync_r[SYNC_STAGES-1] & ~sclk_prev_r;
    assign cs_rise_s    = cs_sync_r[SYNC_STAGES-1] & ~cs_prev_r;
    assign cs_fall_s    = ~cs_sync_r[SYNC_STAGES-1] & cs_prev_r;
    assign mosi_s       = mosi_sync_r[SYNC_STAGES-1];
    assign shift_next_s = {shreg_r[FRAME_BITS-2:0], mosi_s};
    assign cmd_s        = shreg_r[FRAME_BITS-1 -: 4];
    assign addr_s       = shreg_r[FRAME_BITS-5 -: 4];
    assign frame_ok_s   = (bitcnt_r == CNT_FULL) && !ovf_r;

    // Frame start values: an sclk rise coincident with the cs_n fall is the first bit.
    always_comb begin
        start_cnt_s   = {CNT_W{1'b0}};
        start_shreg_s = {FRAME_BITS{1'b0}};
        if (sclk_rise_s) begin
            start_cnt_s   = CNT_W'(1);
            start_shreg_s = {{(FRAME_BITS-1){1'b0}}, mosi_s};
        end else begin
            start_cnt_s   = {CNT_W{1'b0}};
            start_shreg_s = {FRAME_BITS{1'b0}};
        end
    end

    // Frame FSM with registered result outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            shreg_r       <= {FRAME_BITS{1'b0}};
            bitcnt_r      <= {CNT_W{1'b0}};
            ovf_r         <= 1'b0;
            frame_valid_r <= 1'b0;
            frame_err_r   <= 1'b0;
            frame_cmd_r   <= 4'h0;
            frame_addr_r  <= 4'h0;
            frame_data_r  <= {DATA_BITS{1'b0}};
            code_x_r      <= {DATA_BITS{1'b0}};
            code_y_r      <= {DATA_BITS{1'b0}};
            frame_cnt_r   <= 16'h0000;
            err_cnt_r     <= 8'h00;
        end else begin
            frame_valid_r <= 1'b0;
            frame_err_r   <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (cs_fall_s) begin
                        state_r  <= ST_SHIFT;
                        shreg_r  <= start_shreg_s;
                        bitcnt_r <= start_cnt_s;
                        ovf_r    <= 1'b0;
                    end else begin
                        state_r  <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    if (cs_rise_s) begin
                        state_r <= ST_CHECK;
                    end else if (sclk_rise_s) begin
                        shreg_r <= shift_next_s;
                        if (bitcnt_r != CNT_SAT) begin
                            bitcnt_r <= bitcnt_r + CNT_W'(1);
                        end else begin
                            bitcnt_r <= bitcnt_r;
                        end
                        if (bitcnt_r >= CNT_FULL) begin
                            ovf_r <= 1'b1;
                        end else begin
                            ovf_r <= ovf_r;
                        end
                    end else begin
                        state_r <= ST_SHIFT;
                    end
                end
                ST_CHECK: begin
                    if (frame_ok_s) begin
                        frame_valid_r <= 1'b1;
                        frame_cmd_r   <= cmd_s;
                        frame_addr_r  <= addr_s;
                        frame_data_r  <= shreg_r[DATA_BITS-1:0];
                        frame_cnt_r   <= frame_cnt_r + 16'd1;
                        if (cmd_s == CMD_WRITE && addr_s == 4'd0) begin
                            code_x_r <= shreg_r[DATA_BITS-1:0];
                        end else if (cmd_s == CMD_WRITE && addr_s == 4'd1) begin
                            code_y_r <= shreg_r[DATA_BITS-1:0];
                        end else begin
                            code_x_r <= code_x_r;
                        end
                    end else begin
                        frame_err_r <= 1'b1;
                        if (err_cnt_r != 8'hFF) begin
                            err_cnt_r <= err_cnt_r + 8'd1;
                        end else begin
                            err_cnt_r <= err_cnt_r;
                        end
                    end
                    // A cs_n fall landing in this cycle opens the next frame directly.
                    if (cs_fall_s) begin
                        state_r  <= ST_SHIFT;
                        shreg_r  <= start_shreg_s;
                        bitcnt_r <= start_cnt_s;
                        ovf_r    <= 1'b0;
                    end else begin
                        state_r  <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign frame_valid = frame_valid_r;
    assign frame_err   = frame_err_r;
    assign frame_cmd   = frame_cmd_r;
    assign frame_addr  = frame_addr_r;
    assign frame_data  = frame_data_r;
    assign code_x      = code_x_r;
    assign code_y      = code_y_r;
    assign frame_cnt   = frame_cnt_r;
    assign err_cnt     = err_cnt_r;

endmodule

// File: tb/tb_dac_spi_frame_rx.sv
// Directed and random frames for dac_spi_frame_rx. The frames are checked against a
// frame-level model that holds the last good fields, the codes and the counters.
module tb_dac_spi_frame_rx;

    localparam int SYNC_STAGES = 2;
    localparam int LATENCY     = SYNC_STAGES + 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        spi_sclk = 1'b0;
    logic        spi_mosi = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        frame_valid;
    logic [3:0]  frame_cmd;
    logic [3:0]  frame_addr;
    logic [15:0] frame_data;
    logic [15:0] code_x;
    logic [15:0] code_y;
    logic        frame_err;
    logic [15:0] frame_cnt;
    logic [7:0]  err_cnt;

    int checks = 0;
    int errors = 0;

    logic [3:0]  m_cmd, m_addr;
    logic [15:0] m_data, m_x, m_y, m_fcnt;
    logic [7:0]  m_ecnt;

    dac_spi_frame_rx #(
        .FRAME_BITS(24), .DATA_BITS(16), .SYNC_STAGES(SYNC_STAGES), .CMD_WRITE(4'h3)
    ) dut (
        .clk(clk), .reset(reset),
        .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n),
        .frame_valid(frame_valid), .frame_cmd(frame_cmd), .frame_addr(frame_addr),
        .frame_data(frame_data), .code_x(code_x), .code_y(code_y),
        .frame_err(frame_err), .frame_cnt(frame_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cmd = 4'h0; m_addr = 4'h0; m_data = 16'h0; m_x = 16'h0; m_y = 16'h0;
        m_fcnt = 16'h0; m_ecnt = 8'h0;
    endtask

    // Frame-level rules: exactly 24 bits is good, anything else is an error.
    task automatic model_frame(input logic [31:0] bits, input int n);
        logic [23:0] w;
        if (n == 24) begin
            w = bits[23:0];
            m_cmd = w[23:20]; m_addr = w[19:16]; m_data = w[15:0];
            m_fcnt = m_fcnt + 16'd1;
            if (m_cmd == 4'h3 && m_addr == 4'd0) m_x = m_data;
            if (m_cmd == 4'h3 && m_addr == 4'd1) m_y = m_data;
        end else begin
            if (m_ecnt != 8'hFF) m_ecnt = m_ecnt + 8'd1;
        end
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, ".frame_cmd"},  {28'h0, frame_cmd},  {28'h0, m_cmd});
        chk({tag, ".frame_addr"}, {28'h0, frame_addr}, {28'h0, m_addr});
        chk({tag, ".frame_data"}, {16'h0, frame_data}, {16'h0, m_data});
        chk({tag, ".code_x"},     {16'h0, code_x},     {16'h0, m_x});
        chk({tag, ".code_y"},     {16'h0, code_y},     {16'h0, m_y});
        chk({tag, ".frame_cnt"},  {16'h0, frame_cnt},  {16'h0, m_fcnt});
        chk({tag, ".err_cnt"},    {24'h0, err_cnt},    {24'h0, m_ecnt});
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        spi_cs_n = 1'b1;
        spi_sclk = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_reset();
        repeat (6) @(negedge clk);
    endtask

    // Mode 0: mosi changes while sclk is low, 4 clk per sclk half period.
    task automatic shift_bits(input logic [31:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            spi_mosi = bits[n-1-i];
            repeat (4) @(negedge clk);
            spi_sclk = 1'b1;
            repeat (4) @(negedge clk);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic send_frame(input string tag, input logic [31:0] bits, input int n);
        int vcnt, ecnt, lat;
        vcnt = 0; ecnt = 0; lat = 0;
        @(negedge clk);
        spi_cs_n = 1'b0;
        repeat (4) @(negedge clk);
        shift_bits(bits, n);
        repeat (4) @(negedge clk);
        spi_cs_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (frame_valid) begin vcnt++; lat = k; end
            if (frame_err)   begin ecnt++; lat = k; end
        end
        model_frame(bits, n);
        chk({tag, ".valid_pulses"}, vcnt, (n == 24) ? 1 : 0);
        chk({tag, ".err_pulses"},   ecnt, (n == 24) ? 0 : 1);
        chk({tag, ".latency"},      lat,  LATENCY);
        chk_outputs(tag);
    endtask

    initial begin
        logic [31:0] rb;
        int          n;
        int          sel;

        // 1: reset values, then a write to X
        do_reset();
        chk("reset.frame_valid", {31'h0, frame_valid}, 32'h0);
        chk("reset.frame_err",   {31'h0, frame_err},   32'h0);
        chk_outputs("reset");
        send_frame("t1", 32'h0030_1234, 24);
        chk("t1.code_x_lit", {16'h0, code_x}, 32'h1234);

        // 2: write to Y, X holds
        send_frame("t2", 32'h0031_ABCD, 24);
        chk("t2.code_y_lit", {16'h0, code_y}, 32'hABCD);

        // 3: non-write cmd still valid, codes untouched
        send_frame("t3", 32'h0020_5555, 24);
        chk("t3.frame_cmd_lit", {28'h0, frame_cmd}, 32'h2);

        // 4: short and long frames
        send_frame("t4a", 32'h0012_3456, 23);
        send_frame("t4b", 32'h01AB_CDEF, 25);
        chk("t4.err_cnt_lit", {24'h0, err_cnt}, 32'h2);

        // 5: sclk toggles with cs_n high are ignored
        spi_mosi = 1'b1;
        for (int i = 0; i < 8; i++) begin
            repeat (4) @(negedge clk);
            spi_sclk = 1'b1;
            repeat (4) @(negedge clk);
            spi_sclk = 1'b0;
        end
        chk("t5.idle_err", {31'h0, frame_err}, 32'h0);
        send_frame("t5", 32'h0031_0001, 24);
        chk("t5.code_y_lit", {16'h0, code_y}, 32'h0001);

        // 6: reset mid-frame after 12 bits
        @(negedge clk);
        spi_cs_n = 1'b0;
        repeat (4) @(negedge clk);
        shift_bits(32'h0000_0ABC, 12);
        do_reset();
        repeat (10) @(negedge clk);
        chk_outputs("t6.after_reset");
        send_frame("t6", 32'h0030_00FF, 24);
        chk("t6.frame_cnt_lit", {16'h0, frame_cnt}, 32'h1);
        chk("t6.err_cnt_lit",   {24'h0, err_cnt},   32'h0);

        // 7: randomized frames, lengths 0/23/24/25
        for (int f = 0; f < 30; f++) begin
            sel = int'($urandom_range(0, 7));
            case (sel)
                0: n = 0;
                1: n = 23;
                2: n = 25;
                default: n = 24;
            endcase
            rb = $urandom;
            if (n == 24) begin
                rb[31:24] = 8'h00;
                rb[23:20] = ($urandom_range(0, 1) == 0) ? 4'h3 : 4'($urandom);
                rb[19:16] = 4'($urandom_range(0, 3));
            end
            send_frame($sformatf("rnd%0d", f), rb, n);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
